led_sweep_controller: RTL and testbench
=======================================

Name: led_sweep_controller

Overview:
- Sequencer driving led_color_mixxer: generates the `contador` sweep mid_idx→max_idx→0 and presents stable `mid_idx`/`max_idx` to the mixer.
- New configuration is accepted only at cycle boundaries, so the mixer never sees a mid-sweep parameter change.
- Step rate comes from a programmable prescaler.
- Sits between game logic (config, start/stop) and the color mixer.

Parameters:
- N, 8, width of contador/mid_idx/max_idx (must match mixer N).
- DIV_W, 16, prescaler divisor width.
- HOLD_TICKS, 4, peak dwell in step ticks (used only with LED_SWEEP_HOLD_EN).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- iniciar  in  1  start pulse; honoured only in OCIOSO.
- parar  in  1  stop request; registered as pending, takes effect at the next cycle end.
- passo_div  in  DIV_W  clocks per step minus one (0 = step every clock); sampled continuously.
- mid_cfg  in  N  requested start index.
- max_cfg  in  N  requested peak index.
- contador  out  N  sweep index to mixer.
- mid_idx  out  N  latched mid to mixer.
- max_idx  out  N  latched max to mixer.
- subindo  out  1  1 while counting up.
- ativo  out  1  1 in any state other than OCIOSO.
- ciclo_fim  out  1  one-clock pulse on completion of each full sweep.
- erro_cfg  out  1  sticky: set when a latched mid_cfg > max_cfg; cleared on the next accepted iniciar.

Behaviour:
- Reset values: contador=0, mid_idx=0, max_idx=0, subindo=0, ativo=0, ciclo_fim=0, erro_cfg=0, parar pending=0, prescaler=0, state=OCIOSO.
- Prescaler:
  - Counts 0..passo_div and emits `tick` on the clock where count==passo_div, then wraps to 0.
  - Held at 0 in OCIOSO and FIM.
- States: OCIOSO, SUBINDO, PICO (macro only), DESCENDO, FIM.
- Config latch (OCIOSO+iniciar, and at FIM):
  - max_idx←max_cfg.
  - mid_idx←min(mid_cfg, max_cfg).
  - erro_cfg←1 if mid_cfg>max_cfg; otherwise erro_cfg is unchanged, except that an accepted iniciar clears it first.
  - contador←new mid_idx.
- OCIOSO:
  - iniciar → latch config, go to SUBINDO (subindo=1, ativo=1) on the next edge.
  - parar is ignored.
- SUBINDO, on tick:
  - contador<max_idx → contador+1.
  - Otherwise (contador==max_idx) → DESCENDO with subindo=0; contador does not move on that tick.
- DESCENDO, on tick:
  - contador>0 → contador−1.
  - contador==0 → FIM.
- FIM (exactly one clock):
  - ciclo_fim=1.
  - If parar is pending: go to OCIOSO, clear pending; contador and the latched indices hold their values.
  - Otherwise: latch config and return to SUBINDO.
- Latency: the first increment occurs passo_div+1 clocks after entering SUBINDO.
- Full-cycle length in ticks (without macro): (max−mid)+1 up, then max+1 down, plus 1 FIM clock.
- Boundaries:
  - max_cfg=0 → contador stays 0; the sweep takes 2 ticks plus FIM.
  - mid_cfg==max_cfg → the first tick transitions straight to DESCENDO.
  - iniciar while ativo → ignored.
  - parar and iniciar asserted together in OCIOSO → start wins; parar is not recorded.
  - parar asserted repeatedly → a single pending flag.
  - passo_div changed mid-sweep → takes effect on the next compare. If the new value is below the current count, the prescaler counts up to its all-ones wrap before the next tick.
  - reset mid-sweep → outputs return to reset values asynchronously; no ciclo_fim.
- No arithmetic overflow: increment is guarded by <max_idx; decrement is guarded by >0.

Optional Feature:
- LED_SWEEP_HOLD_EN defined:
  - On reaching max, SUBINDO → PICO.
  - PICO holds contador=max_idx, subindo=0, for HOLD_TICKS ticks, then goes to DESCENDO.
  - HOLD_TICKS=0 behaves as if the macro were undefined.
- Undefined: PICO state and its counter are absent; SUBINDO → DESCENDO directly.

Decomposition:
- Package led_sweep_pkg holds:
  - state encoding constants: OCIOSO=0, SUBINDO=1, PICO=2, DESCENDO=3, FIM=4; 3-bit state type.
  - default N and DIV_W constants.
- Sub-module led_tick_div: prescaler with ports clock, reset, enable, passo_div and output tick.

Test Plan:
- mid=128, max=200, passo_div=0, iniciar:
  - contador 128→200 (one step per clock), holds 200 for one tick, then 199→0.
  - ciclo_fim high for exactly 1 clock.
  - contador reloads to 128.
- Change cfg to mid=64, max=180 mid-sweep:
  - outputs unchanged until ciclo_fim.
  - Next clock: mid_idx=64, max_idx=180, contador=64.
- passo_div=3:
  - contador changes every 4 clocks.
  - first increment occurs 4 clocks after SUBINDO entry.
- mid_cfg=250, max_cfg=100:
  - mid_idx=100, erro_cfg=1 and stays sticky.
  - Next iniciar with valid cfg clears erro_cfg.
- parar at contador=150 going up:
  - sweep completes down to 0.
  - ciclo_fim pulse, then ativo=0; contador stays 0.
- reset asserted mid-DESCENDO, asynchronously between edges:
  - all outputs 0 immediately.
  - With LED_SWEEP_HOLD_EN, a separate run checks contador=max for HOLD_TICKS=4 ticks.

Source files
------------

// File: rtl/led_sweep_pkg.sv
// State encoding and default widths shared by the LED sweep sequencer.
// The PICO encoding is only reachable when LED_SWEEP_HOLD_EN is defined.
package led_sweep_pkg;

    localparam int N_DEF     = 8;
    localparam int DIV_W_DEF = 16;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        SUBINDO  = 3'd1,
        PICO     = 3'd2,
        DESCENDO = 3'd3,
        FIM      = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/led_tick_div.sv
// Step-rate prescaler: fires tick when the count reaches passo_div, then wraps.
// Held at zero whenever enable is low.
module led_tick_div
    import led_sweep_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] passo_div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = enable && (r_cnt == passo_div);

    // A divisor lowered below the running count lets the counter roll over naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_sweep_controller.sv
// Sweep sequencer for the colour mixer: mid -> max -> 0, config latched only at cycle ends.
// Define LED_SWEEP_HOLD_EN to add the PICO dwell of HOLD_TICKS ticks at the peak.
module led_sweep_controller
    import led_sweep_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int HOLD_TICKS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             parar,
    input  logic [DIV_W-1:0] passo_div,
    input  logic [N-1:0]     mid_cfg,
    input  logic [N-1:0]     max_cfg,
    output logic [N-1:0]     contador,
    output logic [N-1:0]     mid_idx,
    output logic [N-1:0]     max_idx,
    output logic             subindo,
    output logic             ativo,
    output logic             ciclo_fim,
    output logic             erro_cfg
);

    sweep_state_t r_state, w_next;
    logic [N-1:0] r_cnt, r_mid, r_max;
    logic         r_err, r_pend;
    logic         w_tick, w_run, w_latch, w_start, w_cfg_bad;
    logic [N-1:0] w_mid_new;

`ifdef LED_SWEEP_HOLD_EN
    localparam bit HOLD_ON = (HOLD_TICKS != 0);
    localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic [HOLD_W-1:0] r_hold;
    logic              w_hold_done;

    assign w_hold_done = (r_hold == HOLD_W'(HOLD_TICKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (r_state != PICO) begin
            r_hold <= '0;
        end else if (w_tick) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end
`else
    localparam bit HOLD_ON = (HOLD_TICKS < 0);
`endif

    assign w_run     = (r_state == SUBINDO) || (r_state == PICO) || (r_state == DESCENDO);
    assign w_start   = (r_state == OCIOSO) && iniciar;
    assign w_cfg_bad = (mid_cfg > max_cfg);
    assign w_mid_new = w_cfg_bad ? max_cfg : mid_cfg;

    led_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clock     (clock),
        .reset     (reset),
        .enable    (w_run),
        .passo_div (passo_div),
        .tick      (w_tick)
    );

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (iniciar) begin
                    w_next  = SUBINDO;
                    w_latch = 1'b1;
                end
            end
            SUBINDO: begin
                if (w_tick && (r_cnt >= r_max)) begin
                    w_next = HOLD_ON ? PICO : DESCENDO;
                end
            end
`ifdef LED_SWEEP_HOLD_EN
            PICO: begin
                if (w_tick && w_hold_done) begin
                    w_next = DESCENDO;
                end
            end
`endif
            DESCENDO: begin
                if (w_tick && (r_cnt == '0)) begin
                    w_next = FIM;
                end
            end
            FIM: begin
                if (r_pend) begin
                    w_next = OCIOSO;
                end else begin
                    w_next  = SUBINDO;
                    w_latch = 1'b1;
                end
            end
            default: w_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= OCIOSO;
            r_cnt   <= '0;
            r_mid   <= '0;
            r_max   <= '0;
            r_err   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_max <= max_cfg;
                r_mid <= w_mid_new;
                r_cnt <= w_mid_new;
                // Only a fresh start clears the sticky error; cycle-end reloads just accumulate.
                r_err <= w_cfg_bad | (r_err & ~w_start);
            end else if (w_tick) begin
                if ((r_state == SUBINDO) && (r_cnt < r_max)) begin
                    r_cnt <= r_cnt + N'(1);
                end else if ((r_state == DESCENDO) && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - N'(1);
                end
            end
            if ((r_state == FIM) && r_pend) begin
                r_pend <= 1'b0;
            end else if (parar && (r_state != OCIOSO)) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign contador  = r_cnt;
    assign mid_idx   = r_mid;
    assign max_idx   = r_max;
    assign subindo   = (r_state == SUBINDO);
    assign ativo     = (r_state != OCIOSO);
    assign ciclo_fim = (r_state == FIM);
    assign erro_cfg  = r_err;

endmodule

// File: tb/tb_led_sweep_controller.sv
// Directed bench for led_sweep_controller; expected values are hand-derived per scenario.
// Peak-dwell expectations shift by H ticks when LED_SWEEP_HOLD_EN is defined.
module tb_led_sweep_controller;

    localparam int N     = 8;
    localparam int DIV_W = 16;
`ifdef LED_SWEEP_HOLD_EN
    localparam int H = 4;
`else
    localparam int H = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             iniciar = 1'b0;
    logic             parar = 1'b0;
    logic [DIV_W-1:0] passo_div = '0;
    logic [N-1:0]     mid_cfg = '0;
    logic [N-1:0]     max_cfg = '0;
    logic [N-1:0]     contador, mid_idx, max_idx;
    logic             subindo, ativo, ciclo_fim, erro_cfg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    led_sweep_controller #(.N(N), .DIV_W(DIV_W), .HOLD_TICKS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .passo_div (passo_div),
        .mid_cfg   (mid_cfg),
        .max_cfg   (max_cfg),
        .contador  (contador),
        .mid_idx   (mid_idx),
        .max_idx   (max_idx),
        .subindo   (subindo),
        .ativo     (ativo),
        .ciclo_fim (ciclo_fim),
        .erro_cfg  (erro_cfg)
    );

    // Returns at the first negedge after the accepting edge (observation 0).
    task automatic start(input logic [N-1:0] mid, input logic [N-1:0] mx, input logic [DIV_W-1:0] dv);
        @(negedge clock);
        mid_cfg   = mid;
        max_cfg   = mx;
        passo_div = dv;
        iniciar   = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int cycles);
        cycles = 0;
        while (ativo === 1'b1 && cycles < bound) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({contador, mid_idx, max_idx, subindo, ativo, ciclo_fim, erro_cfg} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0",
                     {contador, mid_idx, max_idx, subindo, ativo, ciclo_fim, erro_cfg});
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (ativo !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: ativo got %b want 0", ativo);
        end
    endtask

    task automatic test_basic_sweep();
        logic [N-1:0] exp;
        start(8'd128, 8'd200, 16'd0);
        n_cmp++;
        if ({contador, mid_idx, max_idx, subindo, ativo} !== {8'd128, 8'd128, 8'd200, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_start: got cnt=%0d mid=%0d max=%0d sub=%b act=%b want 128 128 200 1 1",
                     contador, mid_idx, max_idx, subindo, ativo);
        end
        for (int k = 1; k <= 73; k++) begin
            @(negedge clock);
            exp = (k <= 72) ? 8'(128 + k) : 8'd200;
            n_cmp++;
            if (contador !== exp) begin
                n_bad++;
                $display("FAIL up_ramp k=%0d: got %0d want %0d", k, contador, exp);
            end
        end
        n_cmp++;
        if (subindo !== 1'b0) begin
            n_bad++;
            $display("FAIL peak_subindo: got %b want 0", subindo);
        end
    endtask

    task automatic test_cfg_change();
        logic [N-1:0] exp;
        mid_cfg = 8'd64;
        max_cfg = 8'd180;
        for (int k = 74; k <= 274 + H; k++) begin
            @(negedge clock);
            if (k <= 73 + H) exp = 8'd200;
            else if (k <= 273 + H) exp = 8'(273 + H - k);
            else exp = 8'd0;
            n_cmp++;
            if ({contador, mid_idx, max_idx, ciclo_fim} !== {exp, 8'd128, 8'd200, (k == 274 + H)}) begin
                n_bad++;
                $display("FAIL down_ramp k=%0d: got cnt=%0d mid=%0d max=%0d fim=%b want %0d 128 200 %b",
                         k, contador, mid_idx, max_idx, ciclo_fim, exp, (k == 274 + H));
            end
        end
        @(negedge clock);
        n_cmp++;
        if ({mid_idx, max_idx, contador, ciclo_fim, subindo} !== {8'd64, 8'd180, 8'd64, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reload: got mid=%0d max=%0d cnt=%0d fim=%b sub=%b want 64 180 64 0 1",
                     mid_idx, max_idx, contador, ciclo_fim, subindo);
        end
    endtask

    task automatic test_parar();
        int rel, pulses;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (contador === 8'd150 && subindo === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL parar_reach: got cnt=%0d want 150 rising", contador);
        end
        parar  = 1'b1;
        rel    = 0;
        pulses = 0;
        while (ativo === 1'b1 && rel < 400) begin
            @(negedge clock);
            rel++;
            parar   = (rel == 50);
            iniciar = (rel == 100);
            if (ciclo_fim === 1'b1) pulses++;
        end
        parar   = 1'b0;
        iniciar = 1'b0;
        n_cmp++;
        if (rel !== 213 + H) begin
            n_bad++;
            $display("FAIL parar_stop_time: got %0d clocks want %0d", rel, 213 + H);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL parar_fim_pulses: got %0d want 1", pulses);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({ativo, contador, mid_idx, max_idx} !== {1'b0, 8'd0, 8'd64, 8'd180}) begin
            n_bad++;
            $display("FAIL parar_idle: got act=%b cnt=%0d mid=%0d max=%0d want 0 0 64 180",
                     ativo, contador, mid_idx, max_idx);
        end
    endtask

    task automatic test_prescaler();
        int cyc;
        start(8'd10, 8'd12, 16'd3);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 3) begin
                n_cmp++;
                if (contador !== 8'd10) begin
                    n_bad++;
                    $display("FAIL div_hold: got %0d want 10", contador);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (contador !== 8'd11) begin
                    n_bad++;
                    $display("FAIL div_first_step: got %0d want 11", contador);
                end
            end
            if (k == 5) passo_div = 16'd5;
            if (k == 9) begin
                n_cmp++;
                if (contador !== 8'd11) begin
                    n_bad++;
                    $display("FAIL div_change_hold: got %0d want 11", contador);
                end
            end
            if (k == 10) begin
                n_cmp++;
                if (contador !== 8'd12) begin
                    n_bad++;
                    $display("FAIL div_change_step: got %0d want 12", contador);
                end
            end
            if (k == 16) begin
                n_cmp++;
                if ({contador, subindo} !== {8'd12, 1'b0}) begin
                    n_bad++;
                    $display("FAIL div_peak: got cnt=%0d sub=%b want 12 0", contador, subindo);
                end
            end
        end
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        wait_idle(400, cyc);
        n_cmp++;
        if (ativo !== 1'b0) begin
            n_bad++;
            $display("FAIL div_idle: got ativo=%b after %0d clocks want 0", ativo, cyc);
        end
        passo_div = 16'd0;
    endtask

    task automatic test_cfg_error();
        int cyc;
        start(8'd250, 8'd100, 16'd0);
        n_cmp++;
        if ({mid_idx, max_idx, contador, erro_cfg} !== {8'd100, 8'd100, 8'd100, 1'b1}) begin
            n_bad++;
            $display("FAIL err_latch: got mid=%0d max=%0d cnt=%0d err=%b want 100 100 100 1",
                     mid_idx, max_idx, contador, erro_cfg);
        end
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        n_cmp++;
        if ({subindo, contador} !== {1'b0, 8'd100}) begin
            n_bad++;
            $display("FAIL mid_eq_max: got sub=%b cnt=%0d want 0 100", subindo, contador);
        end
        wait_idle(400, cyc);
        n_cmp++;
        if ({ativo, erro_cfg} !== 2'b01) begin
            n_bad++;
            $display("FAIL err_sticky: got act=%b err=%b want 0 1", ativo, erro_cfg);
        end
        start(8'd1, 8'd2, 16'd0);
        n_cmp++;
        if ({erro_cfg, mid_idx} !== {1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b mid=%0d want 0 1", erro_cfg, mid_idx);
        end
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        wait_idle(100, cyc);
    endtask

    task automatic test_start_priority();
        int cyc;
        @(negedge clock);
        parar = 1'b1;
        @(negedge clock);
        mid_cfg = 8'd2;
        max_cfg = 8'd3;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        parar   = 1'b0;
        for (int k = 1; k <= 7 + H; k++) begin
            @(negedge clock);
            if (k == 6 + H) begin
                n_cmp++;
                if (ciclo_fim !== 1'b1) begin
                    n_bad++;
                    $display("FAIL prio_fim: got %b want 1", ciclo_fim);
                end
            end
            if (k == 7 + H) begin
                n_cmp++;
                if ({ativo, contador} !== {1'b1, 8'd2}) begin
                    n_bad++;
                    $display("FAIL prio_continue: got act=%b cnt=%0d want 1 2", ativo, contador);
                end
            end
        end
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        wait_idle(100, cyc);
        n_cmp++;
        if (ativo !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_idle: got ativo=%b after %0d clocks want 0", ativo, cyc);
        end
    endtask

    task automatic test_zero_max();
        start(8'd0, 8'd0, 16'd0);
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        repeat (1 + H) @(negedge clock);
        n_cmp++;
        if ({ciclo_fim, contador} !== {1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL zero_fim: got fim=%b cnt=%0d want 1 0", ciclo_fim, contador);
        end
        @(negedge clock);
        n_cmp++;
        if ({ativo, ciclo_fim} !== 2'b00) begin
            n_bad++;
            $display("FAIL zero_idle: got act=%b fim=%b want 0 0", ativo, ciclo_fim);
        end
    endtask

`ifdef LED_SWEEP_HOLD_EN
    task automatic test_hold();
        int cyc;
        logic [N-1:0] exp;
        start(8'd3, 8'd4, 16'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            exp = (k <= 6) ? 8'd4 : 8'd3;
            n_cmp++;
            if (contador !== exp || (k >= 2 && subindo !== 1'b0)) begin
                n_bad++;
                $display("FAIL hold k=%0d: got cnt=%0d sub=%b want %0d", k, contador, subindo, exp);
            end
        end
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        wait_idle(100, cyc);
    endtask
`endif

    task automatic test_reset_async();
        logic [N-1:0] exp;
        start(8'd5, 8'd9, 16'd0);
        repeat (7) @(negedge clock);
        exp = (H == 0) ? 8'd7 : 8'd9;
        n_cmp++;
        if (contador !== exp) begin
            n_bad++;
            $display("FAIL rst_pre: got %0d want %0d", contador, exp);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({contador, mid_idx, max_idx, subindo, ativo, ciclo_fim, erro_cfg} !== 28'd0) begin
            n_bad++;
            $display("FAIL rst_async: got %h want 0",
                     {contador, mid_idx, max_idx, subindo, ativo, ciclo_fim, erro_cfg});
        end
        @(negedge clock);
        n_cmp++;
        if ({contador, ativo, ciclo_fim} !== 10'd0) begin
            n_bad++;
            $display("FAIL rst_held: got cnt=%0d act=%b fim=%b want 0 0 0", contador, ativo, ciclo_fim);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({ativo, ciclo_fim} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_release: got act=%b fim=%b want 0 0", ativo, ciclo_fim);
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_cfg_change();
        test_parar();
        test_prescaler();
        test_cfg_error();
        test_start_priority();
        test_zero_max();
`ifdef LED_SWEEP_HOLD_EN
        test_hold();
`endif
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule
